// File: rtl/ysyx_24080014_pkg.sv
// Shared definitions for the ysyx_24080014 load/store unit: FSM states,
// RV32 width codes, byte-mask patterns and small request-decode helpers.
package ysyx_24080014_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } lsu_width_e;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   localparam int CNT_W = 8;

   // Stores only have B/H/W forms; the unsigned codes are load-only.
   function automatic logic f3Legal(input logic isStore, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~isStore;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (f3)
         F3_H, F3_HU: mis = off[0];
         F3_W:        mis = (off != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [7:0] storeWmask(input logic [2:0] f3, input logic [1:0] off);
      logic [7:0] m;
      m = 8'h00;
      case (f3)
         F3_B:    m = {4'b0000, MASK_B << off};
         F3_H:    m = {4'b0000, MASK_H << off};
         F3_W:    m = {4'b0000, MASK_W};
         default: m = 8'h00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ysyx_24080014_lsu_if.sv
// Memory-stage bus between the LSU (master) and the data memory (slave).
interface ysyx_24080014_lsu_if;

   logic        valid;
   logic        ren;
   logic        wen;
   logic [31:0] addr;
   logic [7:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (
      output valid, ren, wen, addr, wmask, wdata,
      input  rdata, ready
   );

   modport slave (
      input  valid, ren, wen, addr, wmask, wdata,
      output rdata, ready
   );

endinterface

// File: rtl/ysyx_24080014_load_align.sv
// Combinational load alignment: moves the addressed lane down to bit 0
// and zero/sign-extends it according to the RV32 width code.
module ysyx_24080014_load_align
   import ysyx_24080014_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {off_i, 3'b000};

   always_comb begin
      data_o = 32'h0;
      case (funct3_i)
         F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    data_o = shifted;
         F3_BU:   data_o = {24'h0, shifted[7:0]};
         F3_HU:   data_o = {16'h0, shifted[15:0]};
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// RV32 load/store unit: accepts one execute-stage request, issues a single
// memory access with a watchdog, then holds the response until taken.
module ysyx_24080014_lsu
   import ysyx_24080014_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic                       is_load_i,
   input  logic                       is_store_i,
   input  logic [2:0]                 funct3_i,
   input  logic [31:0]                addr_i,
   input  logic [31:0]                wdata_i,
   ysyx_24080014_lsu_if.master        mem,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [31:0]                out_rdata_o,
   output logic                       out_misalign_o,
   output logic                       out_err_o
);

   lsu_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              is_load_q;
   logic [2:0]        funct3_q;
   logic [1:0]        off_q;
   logic              in_ready_q;
   logic              mem_valid_q;
   logic              mem_ren_q;
   logic              mem_wen_q;
   logic [31:0]       mem_addr_q;
   logic [7:0]        mem_wmask_q;
   logic [31:0]       mem_wdata_q;
   logic              out_valid_q;
   logic [31:0]       out_rdata_q;
   logic              out_misalign_q;
   logic              out_err_q;

   logic              accept;
   logic              req_err_d;
   logic              req_mis_d;
   logic              req_mem_d;
   logic [7:0]        mem_wmask_d;
   logic [31:0]       mem_wdata_d;
   logic              timeout_hit;
   logic [31:0]       load_data;

   assign accept      = in_valid_i & in_ready_q;
   assign req_err_d   = (is_load_i & is_store_i) |
                        ((is_load_i | is_store_i) & ~f3Legal(is_store_i, funct3_i));
   assign req_mis_d   = (is_load_i | is_store_i) & isMisaligned(funct3_i, addr_i[1:0]);
   assign req_mem_d   = is_load_i | is_store_i;
   assign mem_wmask_d = is_store_i ? storeWmask(funct3_i, addr_i[1:0]) : 8'h00;
   assign mem_wdata_d = wdata_i << {addr_i[1:0], 3'b000};
   assign cnt_d       = cnt_q + 1'b1;
   // mem_ready is tested before this, so a reply on the last allowed cycle still completes.
   assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT));

   ysyx_24080014_load_align u_load_align (
      .rdata_i  (mem.rdata),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .data_o   (load_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         is_load_q      <= 1'b0;
         funct3_q       <= 3'b000;
         off_q          <= 2'b00;
         in_ready_q     <= 1'b1;
         mem_valid_q    <= 1'b0;
         mem_ren_q      <= 1'b0;
         mem_wen_q      <= 1'b0;
         mem_addr_q     <= 32'h0;
         mem_wmask_q    <= 8'h00;
         mem_wdata_q    <= 32'h0;
         out_valid_q    <= 1'b0;
         out_rdata_q    <= 32'h0;
         out_misalign_q <= 1'b0;
         out_err_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  in_ready_q <= 1'b0;
                  is_load_q  <= is_load_i;
                  funct3_q   <= funct3_i;
                  off_q      <= addr_i[1:0];
                  cnt_q      <= '0;
                  if (req_err_d) begin
                     state_q     <= ST_RESP;
                     out_valid_q <= 1'b1;
                     out_err_q   <= 1'b1;
                     out_rdata_q <= 32'h0;
                  end else if (req_mis_d) begin
                     state_q        <= ST_RESP;
                     out_valid_q    <= 1'b1;
                     out_misalign_q <= 1'b1;
                     out_rdata_q    <= 32'h0;
                  end else if (req_mem_d) begin
                     state_q     <= ST_MEM;
                     mem_valid_q <= 1'b1;
                     mem_ren_q   <= is_load_i;
                     mem_wen_q   <= is_store_i;
                     mem_addr_q  <= {addr_i[31:2], 2'b00};
                     mem_wmask_q <= mem_wmask_d;
                     mem_wdata_q <= mem_wdata_d;
                  end else begin
                     state_q     <= ST_RESP;
                     out_valid_q <= 1'b1;
                     out_rdata_q <= 32'h0;
                  end
               end
            end
            ST_MEM: begin
               if (mem.ready || timeout_hit) begin
                  state_q     <= ST_RESP;
                  cnt_q       <= '0;
                  mem_valid_q <= 1'b0;
                  mem_ren_q   <= 1'b0;
                  mem_wen_q   <= 1'b0;
                  mem_addr_q  <= 32'h0;
                  mem_wmask_q <= 8'h00;
                  mem_wdata_q <= 32'h0;
                  out_valid_q <= 1'b1;
                  if (mem.ready) begin
                     out_rdata_q <= is_load_q ? load_data : 32'h0;
                     out_err_q   <= 1'b0;
                  end else begin
                     out_rdata_q <= 32'h0;
                     out_err_q   <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RESP: begin
               if (out_ready_i) begin
                  state_q        <= ST_IDLE;
                  in_ready_q     <= 1'b1;
                  out_valid_q    <= 1'b0;
                  out_rdata_q    <= 32'h0;
                  out_misalign_q <= 1'b0;
                  out_err_q      <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready_o     = in_ready_q;
   assign mem.valid      = mem_valid_q;
   assign mem.ren        = mem_ren_q;
   assign mem.wen        = mem_wen_q;
   assign mem.addr       = mem_addr_q;
   assign mem.wmask      = mem_wmask_q;
   assign mem.wdata      = mem_wdata_q;
   assign out_valid_o    = out_valid_q;
   assign out_rdata_o    = out_rdata_q;
   assign out_misalign_o = out_misalign_q;
   assign out_err_o      = out_err_q;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed bench for ysyx_24080014_lsu built with TIMEOUT=4; the bench plays
// the memory side and checks every observation with an immediate assertion.
module tb_ysyx_24080014_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        is_load;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic        out_misalign;
   logic        out_err;

   int assertCount = 0;
   int failCount   = 0;

   ysyx_24080014_lsu_if memBus ();

   ysyx_24080014_lsu #(.TIMEOUT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .is_load_i      (is_load),
      .is_store_i     (is_store),
      .funct3_i       (funct3),
      .addr_i         (addr),
      .wdata_i        (wdata),
      .mem            (memBus),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .out_rdata_o    (out_rdata),
      .out_misalign_o (out_misalign),
      .out_err_o      (out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Presents one request for exactly one edge; the DUT must be idle beforehand.
   task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd);
      checkOutput("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
      is_load  = ld;
      is_store = st;
      funct3   = f3;
      addr     = a;
      wdata    = wd;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      funct3   = 3'b000;
      addr     = 32'h0;
      wdata    = 32'h0;
   endtask

   task automatic releaseResp(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, ".idle_out_valid"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, ".idle_in_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   task automatic memReply(input logic [31:0] rd);
      memBus.rdata = rd;
      memBus.ready = 1'b1;
      tick();
      memBus.ready = 1'b0;
      memBus.rdata = 32'h0;
   endtask

   task automatic loadCase(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] expRdata);
      applyStimulus(1'b1, 1'b0, f3, a, 32'h0);
      checkOutput({tag, ".mem_valid"}, {31'b0, memBus.valid}, 32'd1);
      checkOutput({tag, ".mem_ren"}, {31'b0, memBus.ren}, 32'd1);
      checkOutput({tag, ".mem_wmask"}, {24'b0, memBus.wmask}, 32'h0);
      checkOutput({tag, ".mem_addr"}, memBus.addr, {a[31:2], 2'b00});
      memReply(rd);
      checkOutput({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, ".out_rdata"}, out_rdata, expRdata);
      checkOutput({tag, ".out_err"}, {31'b0, out_err}, 32'd0);
      checkOutput({tag, ".mem_valid_after"}, {31'b0, memBus.valid}, 32'd0);
      releaseResp(tag);
   endtask

   task automatic storeCase(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [7:0] expMask,
                            input logic [31:0] expWdata);
      applyStimulus(1'b0, 1'b1, f3, a, wd);
      checkOutput({tag, ".mem_valid"}, {31'b0, memBus.valid}, 32'd1);
      checkOutput({tag, ".mem_wen"}, {31'b0, memBus.wen}, 32'd1);
      checkOutput({tag, ".mem_ren"}, {31'b0, memBus.ren}, 32'd0);
      checkOutput({tag, ".mem_addr"}, memBus.addr, {a[31:2], 2'b00});
      checkOutput({tag, ".mem_wmask"}, {24'b0, memBus.wmask}, {24'b0, expMask});
      checkOutput({tag, ".mem_wdata"}, memBus.wdata, expWdata);
      checkOutput({tag, ".in_ready_busy"}, {31'b0, in_ready}, 32'd0);
      memReply(32'hFFFF_FFFF);
      checkOutput({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, ".out_rdata"}, out_rdata, 32'h0);
      checkOutput({tag, ".out_err"}, {31'b0, out_err}, 32'd0);
      releaseResp(tag);
   endtask

   task automatic shortResp(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic expMis, input logic expErr);
      applyStimulus(ld, st, f3, a, 32'h5555_AAAA);
      checkOutput({tag, ".mem_valid"}, {31'b0, memBus.valid}, 32'd0);
      checkOutput({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, ".out_misalign"}, {31'b0, out_misalign}, {31'b0, expMis});
      checkOutput({tag, ".out_err"}, {31'b0, out_err}, {31'b0, expErr});
      checkOutput({tag, ".out_rdata"}, out_rdata, 32'h0);
      releaseResp(tag);
   endtask

   initial begin
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      is_load      = 1'b0;
      is_store     = 1'b0;
      funct3       = 3'b000;
      addr         = 32'h0;
      wdata        = 32'h0;
      out_ready    = 1'b0;
      memBus.ready = 1'b0;
      memBus.rdata = 32'h0;

      tick();
      tick();
      checkOutput("reset.in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("reset.mem_valid", {31'b0, memBus.valid}, 32'd0);
      checkOutput("reset.out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset.out_rdata", out_rdata, 32'h0);
      rst_n = 1'b1;
      tick();

      storeCase("sb_lane3", 3'b000, 32'h8000_0003, 32'h1234_56AB, 8'h08, 32'hAB00_0000);
      storeCase("sh_lane2", 3'b001, 32'h8000_0002, 32'h0000_BEEF, 8'h0C, 32'hBEEF_0000);
      storeCase("sw_word",  3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 8'h0F, 32'hDEAD_BEEF);

      loadCase("lb_neg",  3'b000, 32'h8000_0002, 32'h0080_0000, 32'hFFFF_FF80);
      loadCase("lbu",     3'b100, 32'h8000_0002, 32'h0080_0000, 32'h0000_0080);
      loadCase("lhu",     3'b101, 32'h8000_0002, 32'h8001_0000, 32'h0000_8001);
      loadCase("lh_neg",  3'b001, 32'h8000_0002, 32'h8001_0000, 32'hFFFF_8001);
      loadCase("lb_pos1", 3'b000, 32'h8000_0001, 32'h0000_7F00, 32'h0000_007F);
      loadCase("lw",      3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      shortResp("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h8000_0006, 1'b1, 1'b0);
      shortResp("sh_misalign", 1'b0, 1'b1, 3'b001, 32'h8000_0001, 1'b1, 1'b0);
      shortResp("ld_and_st",   1'b1, 1'b1, 3'b010, 32'h8000_0000, 1'b0, 1'b1);
      shortResp("bad_funct3",  1'b1, 1'b0, 3'b011, 32'h8000_0000, 1'b0, 1'b1);
      shortResp("no_access",   1'b0, 1'b0, 3'b010, 32'h8000_0000, 1'b0, 1'b0);

      // Watchdog expiry: four MEM cycles with no reply.
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("timeout.mem_valid_held", {31'b0, memBus.valid}, 32'd1);
         checkOutput("timeout.out_valid_low", {31'b0, out_valid}, 32'd0);
         tick();
      end
      checkOutput("timeout.out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("timeout.out_err", {31'b0, out_err}, 32'd1);
      checkOutput("timeout.out_rdata", out_rdata, 32'h0);
      checkOutput("timeout.mem_valid", {31'b0, memBus.valid}, 32'd0);
      releaseResp("timeout");

      // Reply on the last allowed cycle wins over the watchdog.
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("lastcycle.mem_valid_held", {31'b0, memBus.valid}, 32'd1);
         tick();
      end
      checkOutput("lastcycle.mem_valid_4th", {31'b0, memBus.valid}, 32'd1);
      memReply(32'h1122_3344);
      checkOutput("lastcycle.out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("lastcycle.out_err", {31'b0, out_err}, 32'd0);
      checkOutput("lastcycle.out_rdata", out_rdata, 32'h1122_3344);
      releaseResp("lastcycle");

      // Stray mem_ready while idle must not produce anything.
      memBus.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("idle_ready.out_valid", {31'b0, out_valid}, 32'd0);
         checkOutput("idle_ready.in_ready", {31'b0, in_ready}, 32'd1);
      end
      memBus.ready = 1'b0;

      // Response back-pressure, with a competing request and stray mem_ready.
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
      memReply(32'hCAFE_F00D);
      is_load      = 1'b1;
      funct3       = 3'b010;
      addr         = 32'h8000_0040;
      in_valid     = 1'b1;
      memBus.ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold.out_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("hold.out_rdata", out_rdata, 32'hCAFE_F00D);
         checkOutput("hold.in_ready", {31'b0, in_ready}, 32'd0);
         checkOutput("hold.mem_valid", {31'b0, memBus.valid}, 32'd0);
         tick();
      end
      in_valid     = 1'b0;
      is_load      = 1'b0;
      memBus.ready = 1'b0;
      checkOutput("hold.out_rdata_end", out_rdata, 32'hCAFE_F00D);
      releaseResp("hold");
      checkOutput("hold.no_accept", {31'b0, memBus.valid}, 32'd0);

      // Reset in the middle of an access abandons it silently.
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0030, 32'h0);
      checkOutput("rst_mem.mem_valid_before", {31'b0, memBus.valid}, 32'd1);
      rst_n = 1'b0;
      tick();
      checkOutput("rst_mem.mem_valid", {31'b0, memBus.valid}, 32'd0);
      checkOutput("rst_mem.in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("rst_mem.out_valid", {31'b0, out_valid}, 32'd0);
      rst_n = 1'b1;
      memReply(32'h8765_4321);
      checkOutput("rst_mem.no_resp", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_mem.still_idle", {31'b0, in_ready}, 32'd1);

      loadCase("post_reset_lw", 3'b010, 32'h8000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/ysyx_24080014_lsu.md
YSYX_24080014_LSU -- requirements
Module: ysyx_24080014_lsu

Interface
REQ-001 Parameter: TIMEOUT, 255, MEM-state cycles without mem_ready before the access is abandoned; legal range 1..255.
REQ-002 Reset and clock: synchronous, active-low reset, single clock domain.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst_n  in  1  synchronous active-low reset.
REQ-005 Port: in_valid  in  1  execute-stage request valid.
REQ-006 Port: in_ready  out  1  LSU can accept a request.
REQ-007 Port: is_load / is_store  in  1 each  access type.
REQ-008 Port: funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 Port: addr  in  32  byte address; wdata  in  32  store source (rs2).
REQ-010 Port: mem_valid, mem_ren, mem_wen  out  1 each  memory-stage request, read enable, write enable.
REQ-011 Port: mem_addr  out  32  word-aligned address; mem_wmask  out  8  byte mask; mem_wdata  out  32  lane-aligned store data.
REQ-012 Port: mem_rdata  in  32  raw word; mem_ready  in  1  memory completion.
REQ-013 Port: out_valid  out  1; out_ready  in  1; out_rdata  out  32  extended load result; out_misalign  out  1; out_err  out  1.

Function
REQ-014 The FSM SHALL have states IDLE, MEM and RESP; in_ready SHALL be 1 only in IDLE.
REQ-015 When in_valid&in_ready, the LSU SHALL latch is_load, is_store, funct3, addr and wdata, then next cycle enter MEM (legal access), RESP with out_misalign=1 (misaligned), RESP with out_err=1 (is_load&is_store, or an undefined funct3 on a load/store), or RESP with out_rdata=0 (no access).
REQ-016 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0; no memory access is issued.
REQ-017 In MEM, mem_valid SHALL be 1 and mem_addr, mem_wmask, mem_wdata, mem_ren, mem_wen SHALL stay stable until mem_ready or timeout.
REQ-018 mem_addr SHALL be {addr[31:2],2'b00}; mem_wmask[7:4] SHALL be 0; mem_wmask[3:0] SHALL be 0001<<addr[1:0] for B, 0011<<addr[1:0] for H, 1111 for W, and all 8 bits 0 for loads.
REQ-019 mem_wdata SHALL be wdata shifted left by 8*addr[1:0].
REQ-020 On mem_ready in MEM, mem_rdata SHALL be shifted right by 8*addr[1:0], zero/sign-extended per funct3, registered into out_rdata (stores: 0), and the FSM SHALL enter RESP next cycle.
REQ-021 The MEM-state counter SHALL reach TIMEOUT without mem_ready => RESP with out_err=1, out_rdata=0, mem_valid deasserted.
REQ-022 mem_ready in the same cycle the counter reaches TIMEOUT SHALL count as completion, not timeout.
REQ-023 In RESP, out_valid SHALL be 1 with stable outputs until out_ready; on out_valid&out_ready the FSM SHALL return to IDLE, with a new request accepted no earlier than the following cycle.
REQ-024 Latency: accept at cycle N, mem_valid at N+1; mem_ready at M => out_valid at M+1.
REQ-025 mem_ready outside MEM SHALL be ignored.

Reset
REQ-026 On rst_n=0 at a clock edge: state IDLE, counter 0, all outputs 0 except in_ready=1; this applies in any state, abandoning an in-flight access with no response.

Structure
REQ-027 State encoding, funct3 width codes and the wmask patterns SHALL live in a shared package ysyx_24080014_pkg.
REQ-028 Load shift-and-extend SHALL be one combinational sub-module ysyx_24080014_load_align.

Verification
REQ-029 SB addr=0x8000_0003 wdata=0x1234_56AB -> mem_addr 0x8000_0000, mem_wmask 0x08, mem_wdata 0xAB00_0000; out_rdata 0.
REQ-030 LB addr=0x8000_0002, mem_rdata=0x0080_0000 -> out_rdata 0xFFFF_FF80; LBU -> 0x0000_0080; LHU addr 0x...2, mem_rdata 0x8001_0000 -> 0x0000_8001.
REQ-031 LW addr=0x8000_0006 -> no mem_valid, out_valid one cycle after accept, out_misalign=1.
REQ-032 TIMEOUT=4, mem_ready never asserted -> mem_valid high 4 cycles, then out_valid with out_err=1; repeat with mem_ready on the 4th cycle -> completion, out_err=0.
REQ-033 out_ready held 0 for 5 cycles -> out_valid and out_rdata stable, in_ready 0 throughout; release -> IDLE next cycle.
REQ-034 rst_n=0 during MEM -> next cycle mem_valid=0, in_ready=1, out_valid=0.
